// File: rtl/usb_tx_pkg.sv
// Shared constants, FSM state type and PID classification helpers for the USB TX packet builder.
package usb_tx_pkg;

    localparam logic [3:0] PID_DATA0 = 4'b0011;
    localparam logic [3:0] PID_DATA1 = 4'b1011;
    localparam logic [3:0] PID_ACK   = 4'b0010;
    localparam logic [3:0] PID_NAK   = 4'b1010;
    localparam logic [3:0] PID_STALL = 4'b1110;

    localparam logic [7:0]  SYNC_BYTE       = 8'h80;
    localparam logic [15:0] CRC16_POLY_REFL = 16'hA001;
    localparam logic [15:0] CRC16_INIT      = 16'hFFFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC_PID,
        ST_FETCH,
        ST_DRAIN,
        ST_CRC,
        ST_DONE
    } tx_state_e;

    function automatic logic pid_is_data(input logic [3:0] pid);
        return (pid == PID_DATA0) || (pid == PID_DATA1);
    endfunction

    function automatic logic pid_is_handshake(input logic [3:0] pid);
        return (pid == PID_ACK) || (pid == PID_NAK) || (pid == PID_STALL);
    endfunction

endpackage

// File: rtl/usb_crc16.sv
// Byte-wide reflected CRC16 next-state: folds one byte, LSB first, into crc_in.
module usb_crc16
    import usb_tx_pkg::*;
(
    input  logic [15:0] crc_in,
    input  logic [7:0]  byte_in,
    output logic [15:0] crc_out
);

    logic [15:0] c;

    always_comb begin
        c = crc_in;
        for (int i = 0; i < 8; i++) begin
            c = c ^ {15'b0, byte_in[i]};
            c = c[0] ? ((c >> 1) ^ CRC16_POLY_REFL) : (c >> 1);
        end
        crc_out = c;
    end

endmodule

// File: rtl/usb_tx_packet_builder.sv
// Builds a flat LSB-first USB TX packet (SYNC, PID, payload, CRC16) from a start strobe and the TX FIFO.
//
// state    | meaning
// IDLE     | waiting for start; requests validated here
// SYNC_PID | write SYNC and PID fields
// FETCH    | pop one FIFO byte per cycle, n cycles
// DRAIN    | capture the last popped byte
// CRC      | write complemented CRC16 field
// DONE     | packet complete, one-cycle pulse
module usb_tx_packet_builder
    import usb_tx_pkg::*;
#(
    parameter int MAX_DATA_BYTES = 64,
    parameter int PKT_W          = 8 * (MAX_DATA_BYTES + 4),
    parameter int CNT_W          = $clog2(PKT_W + 1),
    parameter int BC_W           = $clog2(MAX_DATA_BYTES + 1)
)
(
    input  logic             clk,
    input  logic             n_rst,
    input  logic             start,
    input  logic             abort,
    input  logic [3:0]       pID,
    input  logic [BC_W-1:0]  byte_count,
    input  logic [7:0]       TX_Packet_Data,
    output logic             Get_TX_Packet_Data,
    output logic             busy,
    output logic             packet_load_complete_TX,
    output logic             pid_err,
    output logic [CNT_W-1:0] packet_counter_TX,
    output logic [PKT_W-1:0] packet_TX
);

    localparam logic [BC_W-1:0] MAX_BC = BC_W'(MAX_DATA_BYTES);

    tx_state_e        state_q, state_d;
    logic [3:0]       pid_q;
    logic [BC_W-1:0]  fetch_cnt;
    logic [15:0]      crc_q, crc_next;
    logic             get_q;
    logic             req_valid, start_ok, start_err;

    usb_crc16 u_crc16 (
        .crc_in  (crc_q),
        .byte_in (TX_Packet_Data),
        .crc_out (crc_next)
    );

    assign req_valid = (pid_is_data(pID) && (byte_count <= MAX_BC)) ||
                       (pid_is_handshake(pID) && (byte_count == '0));
    assign start_ok  = (state_q == ST_IDLE) && start && !abort && req_valid;
    assign start_err = (state_q == ST_IDLE) && start && !abort && !req_valid;

    assign busy                    = (state_q != ST_IDLE);
    assign packet_load_complete_TX = (state_q == ST_DONE) && !abort;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d            = state_q;
        Get_TX_Packet_Data = 1'b0;
        unique case (state_q)
            ST_IDLE:     if (start_ok) state_d = ST_SYNC_PID;
            ST_SYNC_PID: begin
                if (pid_is_handshake(pid_q)) state_d = ST_DONE;
                else if (fetch_cnt == '0)    state_d = ST_CRC;
                else                         state_d = ST_FETCH;
            end
            ST_FETCH: begin
                Get_TX_Packet_Data = 1'b1;
                if (fetch_cnt == BC_W'(1)) state_d = ST_DRAIN;
            end
            ST_DRAIN:    state_d = ST_CRC;
            ST_CRC:      state_d = ST_DONE;
            ST_DONE:     state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
        if (abort) begin
            state_d            = ST_IDLE;
            Get_TX_Packet_Data = 1'b0;
        end
    end

    // packet_counter_TX doubles as the write pointer for the next field.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            pid_err           <= 1'b0;
            get_q             <= 1'b0;
            pid_q             <= '0;
            fetch_cnt         <= '0;
            crc_q             <= CRC16_INIT;
            packet_counter_TX <= '0;
            packet_TX         <= '0;
        end else begin
            pid_err <= start_err;
            get_q   <= Get_TX_Packet_Data;
            if (start_ok) begin
                pid_q             <= pID;
                fetch_cnt         <= byte_count;
                crc_q             <= CRC16_INIT;
                packet_counter_TX <= '0;
                packet_TX         <= '0;
            end else begin
                if (state_q == ST_SYNC_PID) begin
                    packet_TX[15:0]   <= {~pid_q, pid_q, SYNC_BYTE};
                    packet_counter_TX <= CNT_W'(16);
                end
                if (Get_TX_Packet_Data)
                    fetch_cnt <= fetch_cnt - BC_W'(1);
                if (get_q) begin
                    packet_TX[packet_counter_TX +: 8] <= TX_Packet_Data;
                    packet_counter_TX                 <= packet_counter_TX + CNT_W'(8);
                    crc_q                             <= crc_next;
                end
                if (state_q == ST_CRC) begin
                    packet_TX[packet_counter_TX +: 16] <= ~crc_q;
                    packet_counter_TX                  <= packet_counter_TX + CNT_W'(16);
                end
            end
        end
    end

endmodule

// File: tb/tb_usb_tx_packet_builder.sv
// Scoreboard bench for usb_tx_packet_builder: expected packets queued at start, popped on done/pid_err.
module tb_usb_tx_packet_builder;
    import usb_tx_pkg::*;

    localparam int PKT_W = 544;
    localparam int CNT_W = 10;
    localparam int BC_W  = 7;

    logic             clk = 1'b0;
    logic             n_rst = 1'b0;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic [3:0]       pID = '0;
    logic [BC_W-1:0]  byte_count = '0;
    logic [7:0]       TX_Packet_Data = '0;
    logic             Get_TX_Packet_Data;
    logic             busy;
    logic             packet_load_complete_TX;
    logic             pid_err;
    logic [CNT_W-1:0] packet_counter_TX;
    logic [PKT_W-1:0] packet_TX;

    usb_tx_packet_builder dut (
        .clk                     (clk),
        .n_rst                   (n_rst),
        .start                   (start),
        .abort                   (abort),
        .pID                     (pID),
        .byte_count              (byte_count),
        .TX_Packet_Data          (TX_Packet_Data),
        .Get_TX_Packet_Data      (Get_TX_Packet_Data),
        .busy                    (busy),
        .packet_load_complete_TX (packet_load_complete_TX),
        .pid_err                 (pid_err),
        .packet_counter_TX       (packet_counter_TX),
        .packet_TX               (packet_TX)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit               is_err;
        logic [PKT_W-1:0] pkt;
        logic [CNT_W-1:0] cnt;
        string            name;
    } exp_t;

    exp_t             sb[$];
    exp_t             mon_e;
    logic [7:0]       fifo[$];
    logic             get_ne = 1'b0;
    int               n_tests = 0;
    int               n_fail = 0;
    logic [PKT_W-1:0] last_pkt = '0;
    logic [CNT_W-1:0] last_cnt = '0;

    task automatic chk(input string name, input logic [PKT_W-1:0] act, input logic [PKT_W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // FIFO model with one cycle read latency
    always @(negedge clk) get_ne = Get_TX_Packet_Data;
    always @(posedge clk) begin
        #1;
        if (get_ne) TX_Packet_Data = (fifo.size() > 0) ? fifo.pop_front() : 8'h00;
    end

    always @(negedge clk) begin
        if (n_rst && (packet_load_complete_TX || pid_err)) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_output: done=%0b err=%0b with empty scoreboard",
                         packet_load_complete_TX, pid_err);
            end else begin
                mon_e = sb.pop_front();
                chk({mon_e.name, "_kind"}, {543'b0, pid_err}, {543'b0, mon_e.is_err});
                chk({mon_e.name, "_pkt"}, packet_TX, mon_e.pkt);
                chk({mon_e.name, "_cnt"}, PKT_W'(packet_counter_TX), PKT_W'(mon_e.cnt));
            end
        end
    end

    function automatic logic [15:0] crc_model(input logic [7:0] d[$]);
        logic [15:0] c = 16'hFFFF;
        logic        fb;
        foreach (d[i])
            for (int b = 0; b < 8; b++) begin
                fb = c[0] ^ d[i][b];
                c  = c >> 1;
                if (fb) c = c ^ 16'hA001;
            end
        return c;
    endfunction

    function automatic logic [PKT_W-1:0] model_pkt(input logic [3:0] pid, input logic [7:0] d[$]);
        logic [PKT_W-1:0] p = '0;
        logic [15:0]      c = ~crc_model(d);
        p[7:0]  = 8'h80;
        p[15:8] = {~pid, pid};
        foreach (d[i]) p[16 + 8*i +: 8] = d[i];
        p[16 + 8*d.size() +: 16] = c;
        return p;
    endfunction

    task automatic run_pkt(input string name, input logic [3:0] pid, input logic [7:0] d[$],
                           input logic [PKT_W-1:0] epkt, input logic [CNT_W-1:0] ecnt, input int edone);
        int j = 0, done_j = 0, gets = 0, first = 0, last = 0, busy_bad = 0;
        int n = d.size();
        exp_t e;
        e.is_err = 1'b0; e.pkt = epkt; e.cnt = ecnt; e.name = name;
        sb.push_back(e);
        fifo = d;
        @(negedge clk);
        pID = pid; byte_count = BC_W'(n); start = 1'b1;
        @(posedge clk);
        while (j < 150 && done_j == 0) begin
            @(negedge clk);
            j++;
            start = 1'b0;
            if (Get_TX_Packet_Data) begin
                gets++;
                if (first == 0) first = j;
                last = j;
            end
            if (!busy) busy_bad++;
            if (packet_load_complete_TX) done_j = j;
        end
        chk({name, "_done_cycle"}, PKT_W'(done_j), PKT_W'(edone));
        chk({name, "_get_count"}, PKT_W'(gets), PKT_W'(n));
        chk({name, "_busy_gaps"}, PKT_W'(busy_bad), '0);
        if (n > 0) begin
            chk({name, "_first_get"}, PKT_W'(first), PKT_W'(2));
            chk({name, "_last_get"}, PKT_W'(last), PKT_W'(1 + n));
        end
        @(negedge clk);
        chk({name, "_busy_after"}, {543'b0, busy}, '0);
        chk({name, "_done_single"}, {543'b0, packet_load_complete_TX}, '0);
        last_pkt = epkt;
        last_cnt = ecnt;
    endtask

    task automatic run_err(input string name, input logic [3:0] pid, input int n);
        exp_t e;
        e.is_err = 1'b1; e.pkt = last_pkt; e.cnt = last_cnt; e.name = name;
        sb.push_back(e);
        @(negedge clk);
        pID = pid; byte_count = BC_W'(n); start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        chk({name, "_err_pulse"}, {543'b0, pid_err}, PKT_W'(1));
        chk({name, "_busy"}, {543'b0, busy}, '0);
        @(negedge clk);
        chk({name, "_err_clear"}, {543'b0, pid_err}, '0);
        chk({name, "_busy2"}, {543'b0, busy}, '0);
    endtask

    initial begin
        logic [7:0]       d[$];
        logic [PKT_W-1:0] p;
        int               gets, j, dones;

        #2;
        chk("rst_busy", {543'b0, busy}, '0);
        chk("rst_get", {543'b0, Get_TX_Packet_Data}, '0);
        chk("rst_pkt", packet_TX, '0);
        chk("rst_cnt", PKT_W'(packet_counter_TX), '0);
        chk("rst_done", {543'b0, packet_load_complete_TX}, '0);
        chk("rst_err", {543'b0, pid_err}, '0);
        repeat (2) @(negedge clk);
        n_rst = 1'b1;

        d = {};
        p = '0; p[15:0] = 16'hD280;
        run_pkt("ack", PID_ACK, d, p, 10'd16, 2);
        p = '0; p[15:0] = 16'h5A80;
        run_pkt("nak", PID_NAK, d, p, 10'd16, 2);
        p = '0; p[31:0] = 32'h0000_C380;
        run_pkt("data0_n0", PID_DATA0, d, p, 10'd32, 3);
        d = {8'h00};
        p = '0; p[39:0] = 40'hBF40_00_4B80;
        run_pkt("data1_n1", PID_DATA1, d, p, 10'd40, 5);

        d = {};
        for (int i = 0; i < 64; i++) d.push_back(8'($urandom_range(0, 255)));
        run_pkt("data0_n64", PID_DATA0, d, model_pkt(PID_DATA0, d), 10'd544, 68);

        run_err("bad_pid", 4'b0001, 0);
        run_err("bc_65", PID_DATA0, 65);
        run_err("nak_n3", PID_NAK, 3);

        d = {};
        for (int i = 0; i < 10; i++) d.push_back(8'(i + 1));
        fifo = d;
        @(negedge clk);
        pID = PID_DATA0; byte_count = 7'd10; start = 1'b1;
        @(posedge clk);
        gets = 0; j = 0;
        while (gets < 5 && j < 40) begin
            @(negedge clk);
            j++;
            start = 1'b0;
            if (Get_TX_Packet_Data) gets++;
        end
        chk("abort_reach_5_pops", PKT_W'(gets), PKT_W'(5));
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", {543'b0, busy}, '0);
        chk("abort_get", {543'b0, Get_TX_Packet_Data}, '0);
        dones = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (packet_load_complete_TX) dones++;
        end
        chk("abort_no_done", PKT_W'(dones), '0);
        fifo.delete();

        d = {};
        p = '0; p[15:0] = 16'hD280;
        run_pkt("ack_after_abort", PID_ACK, d, p, 10'd16, 2);

        d = {};
        for (int i = 0; i < 8; i++) d.push_back(8'(8'hA0 + i));
        fifo = d;
        @(negedge clk);
        pID = PID_DATA1; byte_count = 7'd8; start = 1'b1;
        @(posedge clk);
        gets = 0; j = 0;
        while (gets < 3 && j < 40) begin
            @(negedge clk);
            j++;
            start = 1'b0;
            if (Get_TX_Packet_Data) gets++;
        end
        n_rst = 1'b0;
        #1;
        chk("mid_rst_busy", {543'b0, busy}, '0);
        chk("mid_rst_get", {543'b0, Get_TX_Packet_Data}, '0);
        chk("mid_rst_pkt", packet_TX, '0);
        chk("mid_rst_cnt", PKT_W'(packet_counter_TX), '0);
        @(negedge clk);
        n_rst = 1'b1;
        fifo.delete();

        d = {};
        p = '0; p[15:0] = 16'h1E80;
        run_pkt("stall_after_rst", PID_STALL, d, p, 10'd16, 2);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", PKT_W'(sb.size()), '0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/usb_tx_packet_builder.md
# usb_tx_packet_builder

Parametrised successor to the USB TX packet compiler. It runs its own FSM from a single start strobe instead of following an external TX state. It assembles SYNC, PID, up to MAX_DATA_BYTES payload bytes and a hardware-generated CRC16 into a flat, LSB-first packet vector, and reports the packet length in bits. It sits between the TX data FIFO (read latency 1) and the TX bit serializer/NRZI encoder.

## Interface
- MAX_DATA_BYTES, 64: maximum payload bytes.
- PKT_W, 8*(MAX_DATA_BYTES+4): packet vector width (derived; 544 at default).
- CNT_W, $clog2(PKT_W+1): bit-count width (10 at default).
- clk  in  1  system clock, rising edge.
- n_rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- abort  in  1  synchronous cancel; returns to IDLE.
- pID  in  4  PID latched at start.
- byte_count  in  $clog2(MAX_DATA_BYTES+1)  payload length latched at start.
- TX_Packet_Data  in  8  FIFO byte; valid the cycle after Get_TX_Packet_Data.
- Get_TX_Packet_Data  out  1  FIFO pop, one pulse per byte.
- busy  out  1  high in every state except IDLE.
- packet_load_complete_TX  out  1  one-cycle pulse in DONE.
- pid_err  out  1  one-cycle pulse on rejected request.
- packet_counter_TX  out  CNT_W  valid bit length of packet_TX.
- packet_TX  out  PKT_W  assembled packet; bit 0 is transmitted first.

## Operation
- Reset values: all outputs 0; state IDLE; CRC register 16'hFFFF.
- Supported PIDs:
  - Data class: DATA0 4'b0011, DATA1 4'b1011. Emits SYNC, PID, payload, CRC16.
  - Handshake class: ACK 4'b0010, NAK 4'b1010, STALL 4'b1110. Emits SYNC and PID only.
- Rejected requests: any other pID, byte_count > MAX_DATA_BYTES, or byte_count ≠ 0 with a handshake PID. Response is a pid_err pulse the next cycle, stay IDLE, packet_TX untouched.
- Field layout:
  - packet_TX[7:0] = 8'h80 (SYNC).
  - [15:8] = {~pID, pID}.
  - Byte i at [16+8i +: 8].
  - CRC16 at [16+8n +: 16].
  - Bits above the packet end are 0. On accepted start, packet_TX clears to 0 and packet_counter_TX to 0.
- CRC16: poly 0x8005, reflected (0xA001, right shift), init 16'hFFFF. Updated once per captured byte, LSB first. The CRC field holds the bitwise complement.
- packet_counter_TX: 16 for handshake, 32+8n for data. Updated at SYNC_PID (16) and each field write; final value valid in DONE and held until the next accepted start.
- FSM states and transitions:
  - IDLE → SYNC_PID on valid start.
  - SYNC_PID → DONE (handshake), CRC (data, n=0), or FETCH (n>0).
  - FETCH asserts Get_TX_Packet_Data for exactly n consecutive cycles, then → DRAIN.
  - DRAIN (one cycle) captures the last byte → CRC.
  - CRC writes the CRC field → DONE.
  - DONE → IDLE.
- Byte capture uses a registered copy of Get_TX_Packet_Data. TX_Packet_Data is captured and CRC-updated in every cycle the registered flag is high.
- start while busy: ignored, no error.
- abort in any state: next cycle IDLE, busy 0, Get_TX_Packet_Data 0 that cycle, no completion pulse. packet_TX and packet_counter_TX hold partial contents and are invalid. abort takes priority over start in the same cycle.
- n_rst mid-packet: immediate return to reset values.

## Timing
- Notation: start sampled at edge k; cycle j means the interval after edge j.
- Handshake: SYNC_PID in cycle k+1, packet_load_complete_TX in cycle k+2.
- Data, n=0: CRC in cycle k+2, DONE in cycle k+3.
- Data, n>0:
  - Get_TX_Packet_Data high in cycles k+2..k+1+n.
  - Bytes captured at the ends of cycles k+3..k+2+n.
  - CRC in cycle k+3+n, DONE in cycle k+4+n.
- Back-to-back: the earliest next start is sampled in the cycle after DONE.

## Structure
- Package usb_tx_pkg holds:
  - PID constants.
  - FSM state enum.
  - SYNC_BYTE (8'h80).
  - CRC16_POLY_REFL (16'hA001) and CRC16_INIT (16'hFFFF).
  - A pid_is_data/pid_is_handshake function.
- Sub-module usb_crc16: byte-wide combinational reflected CRC16 next-state (crc_in, byte_in → crc_out). The builder owns the CRC register.

## Test plan
- ACK (4'b0010) start → busy for 2 cycles; packet_TX[15:0]=16'hD280; packet_counter_TX=16; one completion pulse in cycle k+2.
- DATA0, n=0 → no Get_TX_Packet_Data; packet_TX[31:0]=32'h0000_C380; count=32; done in k+3.
- DATA1, n=1, byte 8'h00 → one Get pulse in k+2; [23:16]=8'h00; CRC field [39:24]=16'hBF40; count=40; done in k+5.
- DATA0, n=64, random bytes → 64 contiguous Get pulses; all bytes placed in order; CRC matches the reference model; count=544; done in k+68.
- pID 4'b0001, or byte_count=65, or NAK with n=3 → pid_err pulse; busy stays 0; packet_TX unchanged.
- abort in FETCH after 5 pops → IDLE next cycle; no completion pulse. A following ACK start completes normally. n_rst low mid-FETCH clears all outputs immediately.
